// File: rtl/core_pkg.sv
// Shared core definitions: data width, the canonical NOP encoding,
// the default reset fetch address and the next-pc selection type.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIRECT
  } pc_sel_e;

  // Clears the two byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory lookup, redirect request
// and the valid/ready entry handed to decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if;
  import core_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_inst
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_inst
  );

endinterface

// File: rtl/fetch_unit_program_counter.sv
// Program counter for the fetch stage: holds the byte address of the next
// fetch and picks between a redirect target, sequential +4 and hold.
module program_counter
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_next;

  // Redirect always wins; otherwise advance only when the output register takes this fetch.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_valid) begin
      pc_sel = PC_REDIRECT;
    end else if (load) begin
      pc_sel = PC_INC;
    end
  end

  // Next address; the +4 naturally wraps modulo 2^32 and redirect offsets are dropped.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_REDIRECT: pc_next = align_word(redirect_pc);
      PC_INC:      pc_next = pc + XLEN'(4);
      default:     pc_next = pc;
    endcase
  end

  // PC register, returned to the reset vector asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage. Looks up the word at pc in a
// combinational instruction memory and registers it, with its address,
// into a valid/ready entry for decode. A redirect flushes that entry.
// Optional build macro FETCH_PERF_EN adds handshake/stall counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
`endif
  fetch_unit_if.master    bus
);

  logic [XLEN-1:0] pc;
  logic            load;
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_inst_q;

  // The entry can be (re)filled when it is empty or being consumed this cycle.
  always_comb begin
    load = !id_valid_q || bus.id_ready;
  end

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .pc             (pc)
  );

  // Memory is word indexed, so the byte address drops its low two bits.
  always_comb begin
    bus.imem_addr = {2'b00, pc[XLEN-1:2]};
  end

  // Decode entry: flushed by redirect, refilled on load, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
    end else if (bus.redirect_valid) begin
      id_valid_q <= 1'b0;
    end else if (load) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= pc;
      id_inst_q  <= bus.imem_inst;
    end
  end

  // Entry registers drive the decode-side outputs directly.
  always_comb begin
    bus.id_valid = id_valid_q;
    bus.id_pc    = id_pc_q;
    bus.id_inst  = id_inst_q;
  end

`ifdef FETCH_PERF_EN
  // Completed handshakes and stalled cycles, both free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (id_valid_q && bus.id_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      end
      if (id_valid_q && !bus.id_ready) begin
        perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port imem_addr  output  32  word index to instruction memory, equal to {2'b00, pc[31:2]}.
REQ-005 SHALL have port imem_inst  input  32  combinational instruction word returned for imem_addr in the same cycle.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port id_valid  output  1  decode-side entry valid.
REQ-009 SHALL have port id_ready  input  1  decode stage accepts the entry this cycle.
REQ-010 SHALL have port id_pc  output  32  byte address of the instruction in id_inst.
REQ-011 SHALL have port id_inst  output  32  fetched instruction word.

Function
REQ-012 SHALL hold a 32-bit byte-address register pc; imem_addr is driven combinationally from pc.
REQ-013 SHALL register imem_inst and pc into id_inst/id_pc with id_valid=1 on a load cycle: one cycle of latency from pc to id_* outputs.
REQ-014 SHALL define load = !id_valid || id_ready; on load with no redirect: pc <= pc + 4, output register loads.
REQ-015 SHALL stall when id_valid && !id_ready: pc, id_pc, id_inst and id_valid hold unchanged.
REQ-016 SHALL give redirect_valid priority over load and stall: pc <= {redirect_pc[31:2], 2'b00}, id_valid <= 0 next cycle.
REQ-017 SHALL treat an entry presented with id_valid && id_ready in the redirect cycle as consumed; the next fetched entry is from the redirect target.
REQ-018 SHALL ignore redirect_pc[1:0] (forced to zero); no misalignment signalling.
REQ-019 SHALL wrap pc modulo 2^32: 32'hFFFF_FFFC + 4 yields 32'h0000_0000.
REQ-020 SHALL drive id_pc/id_inst stable while id_valid=1 and id_ready=0.
REQ-021 SHALL never drop or duplicate an instruction absent redirect: each pc value appears on id_* exactly once, in order.

Reset
REQ-022 SHALL on rst_n low, immediately and asynchronously: pc=RESET_PC, id_valid=0, id_pc=32'h0, id_inst=32'h0000_0013 (NOP).
REQ-023 SHALL on first rising edge after rst_n release perform a load of RESET_PC, giving id_valid=1, id_pc=RESET_PC at the following output.
REQ-024 SHALL abandon any stalled entry when reset asserts mid-operation; no state survives reset.

Configuration
REQ-025 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetch_cnt (32) counting completed handshakes (id_valid && id_ready) and perf_stall_cnt (32) counting stall cycles (id_valid && !id_ready), both reset to 0, wrapping at 2^32.
REQ-026 SHALL, without FETCH_PERF_EN, omit both ports and counters entirely; all other behaviour identical.

Structure
REQ-027 SHALL take XLEN (32), NOP instruction constant (32'h0000_0013) and default RESET_PC from the shared package core_pkg.
REQ-028 SHALL place the pc register and next-pc selection (redirect / +4 / hold) in one sub-module, program_counter; output register and handshake stay in fetch_unit.

Verification
REQ-029 SHALL check: reset release with id_ready=1, imem holding 0x00208033 at word 0 -> cycle 1 id_valid=1, id_pc=0x0, id_inst=0x00208033; then id_pc 0x4, 0x8 on successive cycles.
REQ-030 SHALL check: id_ready=0 for 3 cycles while id_pc=0x8 -> id_pc/id_inst held, imem_addr held at 3; on release, next id_pc=0xC.
REQ-031 SHALL check: redirect_valid=1, redirect_pc=0x40 while stalled -> next cycle id_valid=0, imem_addr=16; following cycle id_pc=0x40.
REQ-032 SHALL check: redirect_pc=0x43 -> fetch from 0x40, imem_addr=16.
REQ-033 SHALL check: RESET_PC=32'hFFFF_FFFC, id_ready=1 -> id_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-034 SHALL check: rst_n pulsed low mid-stall -> id_valid=0, id_inst=0x00000013 without a clock edge; with FETCH_PERF_EN, counters read 0.
